jamma_joy_scan_ctrl: RTL



---
 rtl/jamma_joy_scan_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/jamma_joy_scan_ctrl.sv
// jamma_joy_scan_ctrl
//   Sequencer for the external JAMMA/joystick serial shift-register chain.
//   Divides clk12 into the chain shift clock, strobes the parallel load,
//   captures the 24 serial bits into two 12-bit active-low player words,
//   and publishes a per-bit filtered result once per frame. A bit only
//   changes on the outputs after two consecutive frames agree on it.
//
// Ports
//   clk12      in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   scan_en    in   1 = scan continuously, 0 = finish current frame then idle
//   joy_data   in   serial data from the chain
//   joy_clk    out  chain shift clock (registered, 50% duty, period 2*DIV)
//   joy_load   out  chain parallel load, active low (registered)
//   joystick1  out  player 1 word, active low
//   joystick2  out  player 2 word, active low
//   frame_done out  one-cycle pulse when a frame is captured and filtered
module jamma_joy_scan_ctrl #(
  parameter int DIV = 27
) (
  input  logic        clk12,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [4:0]      slot_q, slot_d;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  logic            joy_clk_q, joy_clk_d;
  logic            joy_load_q, joy_load_d;
  logic            frame_done_q, frame_done_d;
  // Packed as {player2[11:0], player1[11:0]}
  logic [23:0]     shadow_q, shadow_d;
  logic [23:0]     prev_q, prev_d;
  logic [23:0]     joy_q, joy_d;
  logic            tick;
  logic [23:0]     differ;

  // Position in {j2, j1} for the bit shifted out during a given slot.
  function automatic logic [4:0] cap_idx(input logic [4:0] slot);
    case (slot)
      5'd2:  cap_idx = 5'd8;
      5'd3:  cap_idx = 5'd6;
      5'd4:  cap_idx = 5'd5;
      5'd5:  cap_idx = 5'd4;
      5'd6:  cap_idx = 5'd3;
      5'd7:  cap_idx = 5'd2;
      5'd8:  cap_idx = 5'd1;
      5'd9:  cap_idx = 5'd0;
      5'd10: cap_idx = 5'd20;
      5'd11: cap_idx = 5'd18;
      5'd12: cap_idx = 5'd17;
      5'd13: cap_idx = 5'd16;
      5'd14: cap_idx = 5'd15;
      5'd15: cap_idx = 5'd14;
      5'd16: cap_idx = 5'd13;
      5'd17: cap_idx = 5'd12;
      5'd18: cap_idx = 5'd22;
      5'd19: cap_idx = 5'd23;
      5'd20: cap_idx = 5'd21;
      5'd21: cap_idx = 5'd19;
      5'd22: cap_idx = 5'd10;
      5'd23: cap_idx = 5'd11;
      5'd24: cap_idx = 5'd9;
      5'd25: cap_idx = 5'd7;
      default: cap_idx = 5'd0;
    endcase
  endfunction

  assign tick = (div_cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    div_cnt_d    = div_cnt_q;
    joy_clk_d    = joy_clk_q;
    joy_load_d   = joy_load_q;
    frame_done_d = 1'b0;
    shadow_d     = shadow_q;
    prev_d       = prev_q;
    joy_d        = joy_q;
    differ       = '0;

    if (state_q == IDLE) begin
      div_cnt_d  = '0;
      joy_clk_d  = 1'b0;
      joy_load_d = 1'b1;
      slot_d     = 5'd0;
      // Leaving idle behaves like a rise tick: slot 0 starts with the
      // clock going high and load going low together.
      if (scan_en) begin
        state_d    = LOAD;
        joy_clk_d  = 1'b1;
        joy_load_d = 1'b0;
      end
    end else if (!tick) begin
      div_cnt_d = div_cnt_q + CW'(1);
    end else begin
      div_cnt_d = '0;
      joy_clk_d = ~joy_clk_q;
      // Rise tick: ends the current slot. Data is taken here, before the
      // chain shifts on the rising joy_clk.
      if (!joy_clk_q) begin
        case (state_q)
          LOAD: begin
            state_d    = SETTLE;
            slot_d     = 5'd1;
            joy_load_d = 1'b1;
          end
          SETTLE: begin
            state_d = SHIFT;
            slot_d  = 5'd2;
          end
          default: begin
            shadow_d[cap_idx(slot_q)] = joy_data;
            if (slot_q == 5'd25) begin
              // Bits that agree with last frame are published, others hold.
              differ       = shadow_d ^ prev_q;
              joy_d        = (~differ & shadow_d) | (differ & joy_q);
              prev_d       = shadow_d;
              frame_done_d = 1'b1;
              slot_d       = 5'd0;
              if (scan_en) begin
                state_d    = LOAD;
                joy_load_d = 1'b0;
              end else begin
                state_d   = IDLE;
                joy_clk_d = 1'b0;
              end
            end else begin
              slot_d = slot_q + 5'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= 5'd0;
      div_cnt_q    <= '0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
      shadow_q     <= '1;
      prev_q       <= '1;
      joy_q        <= '1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      div_cnt_q    <= div_cnt_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      prev_q       <= prev_d;
      joy_q        <= joy_d;
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign frame_done = frame_done_q;
  assign joystick1  = joy_q[11:0];
  assign joystick2  = joy_q[23:12];

endmodule
